// File: rtl/divider.sv
// rtl/divider.sv - sequential restoring divider, signed/unsigned, one quotient bit per cycle
//
// Divides an N-bit dividend by an N-bit divisor over N+1 cycles using a
// start/done handshake. Results hold until the next accepted operation.
//
// Ports:
//   clk         - clock, rising edge
//   reset       - asynchronous active-high reset
//   start       - request a division (taken only while ready=1)
//   sign        - 1: operands are two's-complement signed, 0: unsigned
//   dividend    - numerator, sampled at accept
//   divisor     - denominator, sampled at accept
//   ready       - an operation can be accepted
//   done        - one-cycle pulse, results valid from this cycle on
//   quotient    - result quotient
//   remainder   - result remainder (takes the dividend's sign when signed)
//   div_by_zero - the last operation had divisor == 0
module divider #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         sign,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         ready,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          neg_a_q, neg_a_d;
   logic          neg_b_q, neg_b_d;
   logic          zero_q, zero_d;
   logic [N-1:0]  dd_q, dd_d;      // dividend magnitude shifting out, quotient bits shifting in
   logic [N-1:0]  dvs_q, dvs_d;    // divisor magnitude
   logic [N-1:0]  orig_q, orig_d;  // original dividend, returned on divide by zero
   logic [N:0]    r_q, r_d;        // partial remainder
   logic          ready_q, ready_d;
   logic          done_q, done_d;
   logic [N-1:0]  quot_q, quot_d;
   logic [N-1:0]  rem_q, rem_d;
   logic          dbz_q, dbz_d;

   logic          neg_a_in, neg_b_in;
   logic [N:0]    r_sh;

   assign neg_a_in = sign & dividend[N-1];
   assign neg_b_in = sign & divisor[N-1];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      neg_a_d = neg_a_q;
      neg_b_d = neg_b_q;
      zero_d  = zero_q;
      dd_d    = dd_q;
      dvs_d   = dvs_q;
      orig_d  = orig_q;
      r_d     = r_q;
      ready_d = ready_q;
      done_d  = 1'b0;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      r_sh    = {r_q[N-1:0], dd_q[N-1]};

      case (state_q)
         IDLE: begin
            if (start) begin
               neg_a_d = neg_a_in;
               neg_b_d = neg_b_in;
               zero_d  = (divisor == '0);
               // Negating -2^(N-1) wraps back to 2^(N-1), which is the
               // correct magnitude when read as unsigned.
               dd_d    = neg_a_in ? -dividend : dividend;
               dvs_d   = neg_b_in ? -divisor : divisor;
               orig_d  = dividend;
               r_d     = '0;
               cnt_d   = CW'(N);
               ready_d = 1'b0;
               state_d = CALC;
            end
         end
         CALC: begin
            if (r_sh >= {1'b0, dvs_q}) begin
               r_d  = r_sh - {1'b0, dvs_q};
               dd_d = {dd_q[N-2:0], 1'b1};
            end else begin
               r_d  = r_sh;
               dd_d = {dd_q[N-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = FINISH;
            end
         end
         FINISH: begin
            if (zero_q) begin
               quot_d = '1;
               rem_d  = orig_q;
               dbz_d  = 1'b1;
            end else begin
               // Truncating division: quotient sign from sign mismatch,
               // remainder follows the dividend.
               quot_d = (neg_a_q ^ neg_b_q) ? -dd_q : dd_q;
               rem_d  = neg_a_q ? -r_q[N-1:0] : r_q[N-1:0];
               dbz_d  = 1'b0;
            end
            done_d  = 1'b1;
            ready_d = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
         zero_q  <= 1'b0;
         dd_q    <= '0;
         dvs_q   <= '0;
         orig_q  <= '0;
         r_q     <= '0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         neg_a_q <= neg_a_d;
         neg_b_q <= neg_b_d;
         zero_q  <= zero_d;
         dd_q    <= dd_d;
         dvs_q   <= dvs_d;
         orig_q  <= orig_d;
         r_q     <= r_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   assign ready       = ready_q;
   assign done        = done_q;
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - directed-vector self-checking bench for divider
module tb_divider;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic         sign = 1'b0;
   logic [N-1:0] dividend = '0;
   logic [N-1:0] divisor = '0;
   logic         ready;
   logic         done;
   logic [N-1:0] quotient;
   logic [N-1:0] remainder;
   logic         div_by_zero;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   divider #(.N(N)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .sign        (sign),
      .dividend    (dividend),
      .divisor     (divisor),
      .ready       (ready),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drives an operation from the current (mid-cycle) time, waits for done.
   // lat is the number of edges from the accept edge to the done edge.
   task automatic run_op(input logic s, input logic [N-1:0] a, input logic [N-1:0] b,
                         output int lat, output logic rdy_ok, output int done_cyc);
      sign = s; dividend = a; divisor = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      dividend = 8'h55; divisor = 8'h33; sign = ~s;  // operands may change after accept
      lat = -1; rdy_ok = 1'b1; done_cyc = -1;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = k; done_cyc = cyc;
            if (!ready) rdy_ok = 1'b0;
            break;
         end
         if (ready) rdy_ok = 1'b0;
      end
   endtask

   typedef struct {
      logic         s;
      logic [N-1:0] a, b, q, r;
      logic         dz;
      string        name;
   } vec_t;

   vec_t vecs[$];

   initial begin
      int lat, dcyc, dcyc2;
      logic rdy_ok;
      bit saw_done;

      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, dcyc, dcyc2, ig_lat;
      logic rdy_ok;
      bit saw_done;

      vecs.push_back('{1'b0, 8'd42,  8'd7,   8'd6,   8'd0,   1'b0, "u42/7"});
      vecs.push_back('{1'b1, 8'hD6,  8'd7,   8'hFA,  8'd0,   1'b0, "s-42/7"});
      vecs.push_back('{1'b1, 8'd7,   8'hD6,  8'd0,   8'd7,   1'b0, "s7/-42"});
      vecs.push_back('{1'b1, 8'h9C,  8'd7,   8'hF2,  8'hFE,  1'b0, "s-100/7"});
      vecs.push_back('{1'b1, 8'hF6,  8'hF4,  8'd0,   8'hF6,  1'b0, "s-10/-12"});
      vecs.push_back('{1'b0, 8'd200, 8'd3,   8'd66,  8'd2,   1'b0, "u200/3"});
      vecs.push_back('{1'b1, 8'd200, 8'd3,   8'hEE,  8'hFE,  1'b0, "s-56/3"});
      vecs.push_back('{1'b0, 8'd200, 8'd0,   8'd255, 8'd200, 1'b1, "u200/0"});
      vecs.push_back('{1'b1, 8'h80,  8'hFF,  8'h80,  8'd0,   1'b0, "s-128/-1"});
      vecs.push_back('{1'b1, 8'hF6,  8'd0,   8'hFF,  8'hF6,  1'b1, "s-10/0"});
      vecs.push_back('{1'b0, 8'd255, 8'd16,  8'd15,  8'd15,  1'b0, "u255/16"});

      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", ready, 1);
      check("rst_done", done, 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      check("idle_ready", ready, 1);
      check("idle_q", quotient, 0);
      check("idle_r", remainder, 0);
      check("idle_dz", div_by_zero, 0);

      // Directed table; each op issued mid-cycle right after the previous done
      foreach (vecs[i]) begin
         run_op(vecs[i].s, vecs[i].a, vecs[i].b, lat, rdy_ok, dcyc);
         check($sformatf("%s_lat", vecs[i].name), lat, N + 1);
         check($sformatf("%s_rdy", vecs[i].name), rdy_ok, 1);
         check($sformatf("%s_q", vecs[i].name), quotient, vecs[i].q);
         check($sformatf("%s_r", vecs[i].name), remainder, vecs[i].r);
         check($sformatf("%s_dz", vecs[i].name), div_by_zero, vecs[i].dz);
         if (i == 0) begin
            @(posedge clk); #1;
            check("done_one_cycle", done, 0);
            check("hold_q", quotient, 6);
         end
      end

      // start pulsed in cycle 3 of a busy 42/42 is ignored
      sign = 1'b0; dividend = 8'd42; divisor = 8'd42; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      ig_lat = -1;
      for (int k = 1; k <= 30; k++) begin
         if (k == 3) begin
            dividend = 8'd5; divisor = 8'd5; start = 1'b1;
         end
         @(posedge clk); #1;
         start = 1'b0;
         if (done) begin ig_lat = k; break; end
      end
      check("ign_lat", ig_lat, N + 1);
      check("ign_q", quotient, 1);
      check("ign_r", remainder, 0);
      @(negedge clk);
      repeat (12) begin
         @(posedge clk); #1;
         if (done) saw_done = 1'b1;
      end
      check("ign_no_second_done", saw_done, 0);

      // start in the done cycle accepted; done-to-done spacing N+2
      run_op(1'b0, 8'd100, 8'd10, lat, rdy_ok, dcyc);
      check("b2b_first_q", quotient, 10);
      run_op(1'b0, 8'd99, 8'd4, lat, rdy_ok, dcyc2);
      check("b2b_spacing", dcyc2 - dcyc, N + 2);
      check("b2b_q", quotient, 24);
      check("b2b_r", remainder, 3);

      // reset mid-operation aborts asynchronously
      sign = 1'b0; dividend = 8'd100; divisor = 8'd9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("abort_ready", ready, 1);
      check("abort_done", done, 0);
      check("abort_q", quotient, 0);
      check("abort_r", remainder, 0);
      check("abort_dz", div_by_zero, 0);
      saw_done = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (done) saw_done = 1'b1;
      end
      check("abort_no_done", saw_done, 0);
      run_op(1'b0, 8'd100, 8'd9, lat, rdy_ok, dcyc);
      check("post_rst_lat", lat, N + 1);
      check("post_rst_q", quotient, 11);
      check("post_rst_r", remainder, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
